meta_info_uart_streamer: RTL
============================

// Module: meta_info_uart_streamer
// PURPOSE
//  Downstream consumer of the meta-info character ROM (proj_idx/chr_idx in, 8-bit chr out).
//  On start, walks chr_idx from 0 for one selected project and waits the ROM latency per character.
//  Each non-NUL character is serialised as 8N1 UART; the walk stops at NUL or after MAX_CHARS characters.
//  This turns the project-name table into a readable serial banner for board bring-up.
// PARAMETERS
//  CLKS_PER_BIT  default 16  clock cycles per UART bit; legal range >=2
//  ROM_LAT       default 2   cycles from a chr_idx change to a valid chr_in; legal range >=1
//  MAX_CHARS     default 63  hard cap on characters per string; legal range 1..63
// PORTS
//  clock     in   1  single system clock, rising edge
//  reset     in   1  asynchronous, active-low (0 = in reset)
//  start     in   1  one-cycle request; sampled only in IDLE
//  proj_sel  in   6  project to print; latched on an accepted start
//  chr_in    in   8  character from the ROM; 0x00 terminates the string
//  proj_idx  out  6  ROM project index, holds the latched proj_sel
//  chr_idx   out  6  ROM character index
//  uart_tx   out  1  serial line, idle high
//  busy      out  1  high from an accepted start through the DONE cycle
//  done      out  1  one-cycle pulse when the stream is finished
// BEHAVIOUR
//  Reset: proj_idx=0, chr_idx=0, uart_tx=1, busy=0, done=0, state=IDLE; counters cleared.
//  FSM: IDLE -> FETCH -> CHECK -> SEND -> NEXT -> FETCH ... -> DONE -> IDLE.
//  IDLE: start=1 latches proj_sel into proj_idx, sets chr_idx=0, busy=1, then goes to FETCH.
//  FETCH: holds chr_idx steady for exactly ROM_LAT cycles, then goes to CHECK.
//  CHECK: chr_in==0 -> DONE. Otherwise the character is registered and the FSM goes to SEND.
//  SEND: frame = start bit 0, data[0..7] LSB first, stop bit 1; each bit lasts CLKS_PER_BIT cycles.
//   A frame is 10*CLKS_PER_BIT cycles. No gap beyond the ROM fetch is inserted between frames.
//  NEXT: if chars_sent==MAX_CHARS -> DONE. Otherwise chr_idx+=1 and the FSM goes to FETCH.
//   chr_idx never wraps: its maximum value is MAX_CHARS-1.
//  DONE: done=1 for one cycle while busy is still 1, then the FSM returns to IDLE.
//   In IDLE, chr_idx holds its last value.
//  start while busy: ignored, no queueing. proj_sel changes while busy: ignored.
//  Reset mid-frame: uart_tx goes to 1 asynchronously. The partial frame is lost and no done pulse is issued.
//  uart_tx, done and busy are registered outputs (no combinational paths from inputs).
// CONFIGURATION
//  META_STREAM_CRLF_EN defined: after the last character (NUL or cap), two extra frames are sent.
//   These frames are 0x0D then 0x0A, taken from internal constants rather than the ROM. DONE follows them.
//   This also applies to an empty string, which then emits only CR and LF.
//  Undefined: no trailer; DONE follows the last data frame (or CHECK on NUL) directly.
// STRUCTURE
//  Package meta_stream_pkg holds:
//   state enum (IDLE, FETCH, CHECK, SEND, NEXT, CRLF, DONE);
//   UART_FRAME_BITS=10; ASCII_NUL=8'h00, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
//  Sub-module uart_tx_serializer (parameter CLKS_PER_BIT; ports: clock, reset, load, data[8], tx, ready).
//   It owns the baud counter and bit counter. The streamer FSM pulses load and waits for ready.
//  The top level holds the FSM, index registers, ROM-latency counter and chars_sent counter.
// TESTING
//  Setup: CLKS_PER_BIT=4, ROM_LAT=2. The bench ROM model returns chr_in ROM_LAT cycles after each index.
//  1. proj_sel=5 ROM "AB\0", start pulse:
//     -> uart_tx frames 0x41, 0x42 (40 cycles each, LSB first); chr_idx 0,1,2;
//     -> done pulses once and busy falls the cycle after.
//  2. Empty string (index 0 = 0x00):
//     -> no frame (uart_tx stays 1); done asserted ROM_LAT+2 cycles after start.
//  3. 63 non-NUL 'x' chars, no terminator:
//     -> exactly 63 frames of 0x78; chr_idx peaks at 62 and never reaches 63; then done.
//  4. start pulses during frame 1 of test 1, with proj_sel changed to 9:
//     -> ignored; output identical to test 1; proj_idx stays 5.
//  5. reset=0 held 3 cycles mid-data-bit of frame 1:
//     -> uart_tx=1 immediately, busy=0, no done; a new start then streams correctly.
//  6. With META_STREAM_CRLF_EN, rerun test 1:
//     -> frames 0x41, 0x42, 0x0D, 0x0A, then done; rerun test 2 -> frames 0x0D, 0x0A only.

Source files
------------

// File: rtl/meta_stream_pkg.sv
// meta_stream_pkg: streamer FSM states and UART/ASCII constants shared by the meta-info UART streamer
package meta_stream_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, CHECK, SEND, NEXT, CRLF, DONE} state_t;
   localparam int UART_FRAME_BITS = 10;
   localparam logic [7:0] ASCII_NUL = 8'h00;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter, one frame per accepted load
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset; forces the line idle-high
//   load   start a frame with data (taken only while ready)
//   data   byte to send, LSB first
//   tx     serial line, registered, idle high
//   ready  high while no frame is in flight
module uart_tx_serializer
   import meta_stream_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   logic [BW-1:0] baud;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;
   logic          active;
   assign ready = !active;
   // shreg carries data bits followed by the stop bit; the start bit is driven directly at load
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         tx      <= 1'b1;
         active  <= 1'b0;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '1;
      end else if (!active) begin
         if (load) begin
            tx      <= 1'b0;
            shreg   <= {1'b1, data};
            active  <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
         end
      end else if (baud != BW'(CLKS_PER_BIT - 1)) begin
         baud <= baud + 1'b1;
      end else begin
         baud <= '0;
         if (bit_cnt == 4'(UART_FRAME_BITS - 1)) active <= 1'b0;
         else begin
            tx      <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
endmodule

// File: rtl/meta_info_uart_streamer.sv
// meta_info_uart_streamer: walks one project string of the meta-info ROM and sends it as 8N1 UART
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle request, sampled only when idle
//   proj_sel  project to print, latched on an accepted start
//   chr_in    ROM character, 0x00 ends the string
//   proj_idx  ROM project index (latched proj_sel)
//   chr_idx   ROM character index, never exceeds MAX_CHARS-1
//   uart_tx   serial line, idle high
//   busy      high from accepted start through the done cycle
//   done      one-cycle pulse when the stream has finished
// Optional build macro META_STREAM_CRLF_EN appends a CR LF trailer after the string.
module meta_info_uart_streamer
   import meta_stream_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int ROM_LAT      = 2,
   parameter int MAX_CHARS    = 63
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] proj_sel,
   input  logic [7:0] chr_in,
   output logic [5:0] proj_idx,
   output logic [5:0] chr_idx,
   output logic       uart_tx,
   output logic       busy,
   output logic       done
);
`ifdef META_STREAM_CRLF_EN
   localparam bit CRLF_EN = 1'b1;
`else
   localparam bit CRLF_EN = 1'b0;
`endif
   localparam int LW = $clog2(ROM_LAT + 1);
   state_t        state;
   state_t        end_state;
   logic [LW-1:0] lat_cnt;
   logic [5:0]    chars_sent;
   logic          trailer;
   logic          lf_next;
   logic          load;
   logic          ready;
   logic [7:0]    tx_data;
   // the serializer is always idle when CHECK or CRLF is entered, so load needs no ready qualifier
   assign load      = state == CRLF || (state == CHECK && chr_in != ASCII_NUL);
   assign tx_data   = state == CRLF ? (lf_next ? ASCII_LF : ASCII_CR) : chr_in;
   assign end_state = CRLF_EN ? CRLF : DONE;
   uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .data  (tx_data),
      .tx    (uart_tx),
      .ready (ready)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         proj_idx   <= '0;
         chr_idx    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         lat_cnt    <= '0;
         chars_sent <= '0;
         trailer    <= 1'b0;
         lf_next    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               proj_idx   <= proj_sel;
               chr_idx    <= '0;
               busy       <= 1'b1;
               lat_cnt    <= '0;
               chars_sent <= '0;
               trailer    <= 1'b0;
               lf_next    <= 1'b0;
               state      <= FETCH;
            end
            FETCH: if (lat_cnt == LW'(ROM_LAT - 1)) state <= CHECK;
                   else lat_cnt <= lat_cnt + 1'b1;
            CHECK: if (chr_in == ASCII_NUL) begin
               state   <= end_state;
               trailer <= CRLF_EN;
               done    <= !CRLF_EN;
            end else begin
               chars_sent <= chars_sent + 1'b1;
               state      <= SEND;
            end
            SEND: if (ready) begin
               if (!trailer) state <= NEXT;
               else if (lf_next) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  lf_next <= 1'b1;
                  state   <= CRLF;
               end
            end
            NEXT: if (chars_sent == 6'(MAX_CHARS)) begin
               state   <= end_state;
               trailer <= CRLF_EN;
               done    <= !CRLF_EN;
            end else begin
               chr_idx <= chr_idx + 1'b1;
               lat_cnt <= '0;
               state   <= FETCH;
            end
            CRLF: state <= SEND;
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
